val2_shift_sequencer: RTL and testbench
=======================================

# val2_shift_sequencer

Multi-cycle sequencer for the EX-stage second-operand (Val2) computation. It accepts one operand request at a time, classifies it as memory offset, rotated immediate or shifted register, and performs the shift or rotate iteratively in a registered shift register at up to SHIFT_STEP bit positions per cycle. The result is presented on a valid/ready output. This replaces the single-cycle 32-position barrel shift on the EX critical path. EX holds its pipeline register while `busy` is high.

## Interface
- SHIFT_STEP, 4: maximum bit positions shifted per cycle. Legal values are 1, 2, 4, 8, 16 and 32.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous reset, active-low; sampled on the clk rising edge.
- flush  input  1  abort the current operation; the sequencer returns to IDLE.
- in_valid  input  1  request present.
- in_ready  output  1  the request is accepted on this cycle when in_valid is also high.
- I  input  1  immediate operand flag.
- mem_en  input  1  load/store offset flag; takes priority over I.
- shifter_operand  input  12  instruction bits [11:0].
- val_Rm  input  32  register operand.
- out_valid  output  1  val2 is valid.
- out_ready  input  1  consumer accepts val2.
- val2  output  32  result; held stable while out_valid is high and out_ready is low.
- busy  output  1  high in SHIFT, and in DONE while out_ready is low.

## Operation
- States:
  - IDLE: waiting for a request.
  - SHIFT: shifting in progress.
  - DONE: result is being presented.
- The request is decoded and the registers are loaded on acceptance (in_valid and in_ready both high).
- mem_en = 1: shreg is loaded with shifter_operand sign-extended to 32 bits. rem = 0.
- mem_en = 0, I = 1: shreg is loaded with {24'd0, shifter_operand[7:0]}. op = ROR. rem = 2 × shifter_operand[11:8], a 5-bit value in the range 0 to 30.
- mem_en = 0, I = 0: shreg is loaded with val_Rm. op = shifter_operand[6:5]: LSL = 00, LSR = 01, ASR = 10, ROR = 11. rem = shifter_operand[11:7].
- Shift amount 0 means no shift for every op, including LSR and ASR. There are no ARM special encodings (no LSR #32 and no RRX).
- Each cycle in SHIFT, shreg is shifted by k = min(SHIFT_STEP, rem), and rem decreases by k.
  - LSL and LSR fill with zeros.
  - ASR fills with shreg[31] of the current cycle.
  - ROR rotates right.
- Transitions:
  - IDLE to DONE on acceptance when rem = 0.
  - IDLE to SHIFT on acceptance when rem > 0.
  - SHIFT to DONE on the cycle the update brings rem to 0.
  - DONE to IDLE when out_ready = 1 and there is no new acceptance.
  - DONE to DONE or SHIFT when out_ready = 1 and a new request is accepted in the same cycle (back-to-back operation).
- in_ready = (state == IDLE) or (state == DONE and out_ready), and is forced to 0 while flush = 1.
- out_valid = (state == DONE).
- val2 = shreg.

## Timing
- Reset (rst = 0 at a clock edge): state = IDLE, shreg = 0, rem = 0, op = LSL. Output values during reset:
  - in_ready = 0
  - out_valid = 0
  - val2 = 0
  - busy = 0
- in_ready rises in the first cycle after rst returns high.
- For a request accepted at edge T, out_valid is first high in the cycle after edge T + ceil(amount / SHIFT_STEP).
  - Zero shift and mem_en requests: one cycle.
  - Worst case, ROR 31 with SHIFT_STEP = 1: 32 cycles.
- flush has priority over every other input. On the next edge: state = IDLE, rem = 0, and any result pending in DONE is discarded. shreg keeps its value.
- A request presented together with flush is not accepted.
- rst = 0 mid-operation behaves the same as flush and also clears shreg.
- Inputs are sampled only at acceptance. Changes to shifter_operand, val_Rm, I or mem_en while in SHIFT have no effect.
- Back-to-back operation: when out_ready and in_valid are both high in DONE, the old result is consumed and the new request is loaded on the same edge. There is no bubble.

## Structure
- Package `val2_pkg`:
  - shift op codes LSL, LSR, ASR and ROR (2 bits);
  - state enum IDLE, SHIFT, DONE;
  - localparam REM_W = 5.
- Sub-module `val2_shift_step`: combinational. Inputs are data[31:0], op, and k (0 to SHIFT_STEP). The output is data shifted or rotated by k. It is instantiated once; the sequencer owns all the registers.
- Target size for the sequencer: about 150 lines; target for the step module: about 60 lines.

## Test plan
- mem_en = 1, shifter_operand = 12'hFFC → val2 = 32'hFFFF_FFFC with out_valid one cycle after acceptance; I is ignored.
- I = 1, shifter_operand = 12'h2FF, SHIFT_STEP = 4 (rotate right by 4) → val2 = 32'hF000_000F after 2 cycles.
- val_Rm = 32'h8000_0010 with ASR 4, then LSR 4, then ROR 4, then LSL 31 → results 32'hF800_0001, 32'h0800_0001, 32'h0800_0001 and 32'h0000_0000.
- Back-to-back: four requests with out_ready held at 1 → accepted on consecutive DONE cycles with no idle gap. With out_ready held low, val2 stays stable and in_ready stays 0.
- flush asserted in the 3rd SHIFT cycle of a ROR 31 → IDLE next cycle, out_valid never rises for that request, and the next request completes correctly.
- rst pulsed low during SHIFT → all outputs return to their reset values on the next edge; a repeat with SHIFT_STEP = 1 and amount 31 checks the 32-cycle latency.

Source files
------------

// File: rtl/val2_pkg.sv
// Shared types for the iterative Val2 shift sequencer.
package val2_pkg;

  localparam int unsigned REM_W = 5;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } seq_state_e;

endpackage

// File: rtl/val2_shift_step.sv
// One iteration of the Val2 shifter: shift or rotate data by k (0..SHIFT_STEP) positions.
module val2_shift_step
  import val2_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic [31:0] data,
  input  shift_op_e   op,
  input  logic [5:0]  k,
  output logic [31:0] result
);

  logic [5:0] kk;

  // Bounding k keeps the inferred shifter no wider than one step.
  always_comb begin
    kk = (k > 6'(SHIFT_STEP)) ? 6'(SHIFT_STEP) : k;
  end

  always_comb begin
    result = data;
    unique case (op)
      LSL: result = data << kk;
      LSR: result = data >> kk;
      ASR: result = $signed(data) >>> kk;
      ROR: result = (data >> kk) | (data << (6'd32 - kk));
      default: result = data;
    endcase
  end

endmodule

// File: rtl/val2_shift_sequencer.sv
// Multi-cycle Val2 operand sequencer: decodes the request, then shifts SHIFT_STEP bits per cycle.
module val2_shift_sequencer
  import val2_pkg::*;
#(
  parameter int unsigned SHIFT_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        I,
  input  logic        mem_en,
  input  logic [11:0] shifter_operand,
  input  logic [31:0] val_Rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] val2,
  output logic        busy
);

  seq_state_e       state, state_d;
  logic [31:0]      shreg, shreg_d;
  logic [REM_W-1:0] rem, rem_d;
  shift_op_e        op, op_d;

  logic [31:0]      load_shreg;
  logic [REM_W-1:0] load_rem;
  shift_op_e        load_op;

  logic [5:0]       rem_ext;
  logic [5:0]       k_full;
  logic [REM_W-1:0] rem_next;
  logic [31:0]      step_out;
  logic             accept;

  // Outputs are gated by rst so they read as reset values for the whole reset cycle.
  assign in_ready  = rst && !flush && ((state == IDLE) || ((state == DONE) && out_ready));
  assign out_valid = rst && (state == DONE);
  assign busy      = rst && ((state == SHIFT) || ((state == DONE) && !out_ready));
  assign val2      = rst ? shreg : '0;
  assign accept    = in_valid && in_ready;

  always_comb begin
    load_shreg = val_Rm;
    load_rem   = shifter_operand[11:7];
    load_op    = shift_op_e'(shifter_operand[6:5]);
    if (mem_en) begin
      load_shreg = {{20{shifter_operand[11]}}, shifter_operand};
      load_rem   = '0;
      load_op    = LSL;
    end else if (I) begin
      load_shreg = {24'd0, shifter_operand[7:0]};
      load_rem   = {shifter_operand[11:8], 1'b0};
      load_op    = ROR;
    end
  end

  always_comb begin
    rem_ext  = {1'b0, rem};
    k_full   = (rem_ext < 6'(SHIFT_STEP)) ? rem_ext : 6'(SHIFT_STEP);
    rem_next = REM_W'(rem_ext - k_full);
  end

  val2_shift_step #(
    .SHIFT_STEP(SHIFT_STEP)
  ) u_step (
    .data  (shreg),
    .op    (op),
    .k     (k_full),
    .result(step_out)
  );

  always_comb begin
    state_d = state;
    shreg_d = shreg;
    rem_d   = rem;
    op_d    = op;
    if (flush) begin
      state_d = IDLE;
      rem_d   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            shreg_d = load_shreg;
            rem_d   = load_rem;
            op_d    = load_op;
            state_d = (load_rem == '0) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          shreg_d = step_out;
          rem_d   = rem_next;
          if (rem_next == '0) state_d = DONE;
        end
        DONE: begin
          // A new acceptance here implies out_ready, so the old result is consumed on this edge.
          if (accept) begin
            shreg_d = load_shreg;
            rem_d   = load_rem;
            op_d    = load_op;
            state_d = (load_rem == '0) ? DONE : SHIFT;
          end else if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      shreg <= '0;
      rem   <= '0;
      op    <= LSL;
    end else begin
      state <= state_d;
      shreg <= shreg_d;
      rem   <= rem_d;
      op    <= op_d;
    end
  end

endmodule

// File: tb/tb_val2_shift_sequencer.sv
// Self-checking bench for val2_shift_sequencer: vector table through a scoreboard plus corner sequences.
module tb_val2_shift_sequencer;

  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        I;
  logic        mem_en;
  logic [11:0] shifter_operand;
  logic [31:0] val_Rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] val2;
  logic        busy;

  logic        in_valid1;
  logic        in_ready1;
  logic        out_valid1;
  logic        out_ready1;
  logic [31:0] val2_1;
  logic        busy1;

  always #5 clk = ~clk;

  val2_shift_sequencer #(.SHIFT_STEP(STEP)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .I(I), .mem_en(mem_en), .shifter_operand(shifter_operand), .val_Rm(val_Rm),
    .out_valid(out_valid), .out_ready(out_ready), .val2(val2), .busy(busy)
  );

  val2_shift_sequencer #(.SHIFT_STEP(1)) dut1 (
    .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid1), .in_ready(in_ready1),
    .I(I), .mem_en(mem_en), .shifter_operand(shifter_operand), .val_Rm(val_Rm),
    .out_valid(out_valid1), .out_ready(out_ready1), .val2(val2_1), .busy(busy1)
  );

  typedef struct {
    logic        me;
    logic        ii;
    logic [11:0] so;
    logic [31:0] rm;
    logic [31:0] exp;
    int          amt;
  } vec_t;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } sb_t;

  vec_t vt[16];
  sb_t  q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Scoreboard consumer: first-valid latency and value on handshake.
  always @(negedge clk) begin
    #2;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
      end else begin
        if (!seen) begin
          chk("latency", 32'(cyc), 32'(q[0].cyc));
          seen = 1'b1;
        end
        if (out_ready) begin
          chk("val2", val2, q[0].val);
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic me, input logic ii, input logic [11:0] so, input logic [31:0] rm,
                      input logic [31:0] exp, input int amt, input bit push, output int acc);
    int n = 0;
    acc = -1;
    @(negedge clk);
    mem_en = me; I = ii; shifter_operand = so; val_Rm = rm; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      timeout("accept");
      in_valid = 1'b0;
      return;
    end
    if (push) q.push_back('{exp, cyc + 1 + (amt + STEP - 1) / STEP});
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) timeout("drain");
    @(negedge clk);
    #3;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int accs[4];
    int n;

    vt[0]  = '{1'b1, 1'b1, 12'hFFC, 32'h1234_5678, 32'hFFFF_FFFC, 0};
    vt[1]  = '{1'b0, 1'b1, 12'h2FF, 32'hDEAD_BEEF, 32'hF000_000F, 4};
    vt[2]  = '{1'b0, 1'b0, 12'h240, 32'h8000_0010, 32'hF800_0001, 4};
    vt[3]  = '{1'b0, 1'b0, 12'h220, 32'h8000_0010, 32'h0800_0001, 4};
    vt[4]  = '{1'b0, 1'b0, 12'h260, 32'h8000_0010, 32'h0800_0001, 4};
    vt[5]  = '{1'b0, 1'b0, 12'hF80, 32'h8000_0010, 32'h0000_0000, 31};
    vt[6]  = '{1'b1, 1'b0, 12'h7FF, 32'hFFFF_FFFF, 32'h0000_07FF, 0};
    vt[7]  = '{1'b0, 1'b1, 12'h0AB, 32'hFFFF_FFFF, 32'h0000_00AB, 0};
    vt[8]  = '{1'b0, 1'b1, 12'hF01, 32'h0000_0000, 32'h0000_0004, 30};
    vt[9]  = '{1'b0, 1'b0, 12'h020, 32'h8000_0000, 32'h8000_0000, 0};
    vt[10] = '{1'b0, 1'b0, 12'h040, 32'h8000_0000, 32'h8000_0000, 0};
    vt[11] = '{1'b0, 1'b0, 12'hFC0, 32'h8000_0000, 32'hFFFF_FFFF, 31};
    vt[12] = '{1'b0, 1'b0, 12'hFE0, 32'h0000_0001, 32'h0000_0002, 31};
    vt[13] = '{1'b0, 1'b0, 12'h080, 32'hC000_0001, 32'h8000_0002, 1};
    vt[14] = '{1'b0, 1'b0, 12'h280, 32'h0000_0001, 32'h0000_0020, 5};
    vt[15] = '{1'b0, 1'b0, 12'h2C0, 32'h4000_0000, 32'h0200_0000, 5};

    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_valid1 = 1'b0;
    out_ready = 1'b1; out_ready1 = 1'b1;
    I = 1'b0; mem_en = 1'b0; shifter_operand = '0; val_Rm = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_val2", val2, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Vector table, back-to-back with out_ready held high
    for (int i = 0; i < 16; i++)
      send(vt[i].me, vt[i].ii, vt[i].so, vt[i].rm, vt[i].exp, vt[i].amt, 1'b1, acc);
    drain();

    // Four zero-shift requests must be accepted on consecutive cycles
    for (int i = 0; i < 4; i++)
      send(1'b1, 1'b0, 12'(i + 1), 32'h0, 32'(i + 1), 0, 1'b1, accs[i]);
    for (int i = 1; i < 4; i++) chk("b2b_gap", 32'(accs[i] - accs[i-1]), 32'd1);
    drain();

    // Result held while out_ready is low
    @(negedge clk);
    out_ready = 1'b0;
    send(1'b0, 1'b0, 12'h280, 32'h0000_0001, 32'h0000_0020, 5, 1'b1, acc);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!out_valid) timeout("hold_valid");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk("hold_val2", val2, 32'h0000_0020);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_busy", {31'd0, busy}, 32'd1);
    end
    out_ready = 1'b1;
    drain();

    // Flush in the third SHIFT cycle of ROR 31; a request offered with flush is refused
    send(1'b0, 1'b0, 12'hFE0, 32'h0000_0001, 32'h0, 31, 1'b0, acc);
    repeat (3) @(negedge clk);
    flush = 1'b1;
    mem_en = 1'b1; I = 1'b0; shifter_operand = 12'h123; in_valid = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    chk("flush_busy_before", {31'd0, busy}, 32'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_idle_busy", {31'd0, busy}, 32'd0);
    chk("flush_idle_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("flush_no_valid", {31'd0, out_valid}, 32'd0);
    end
    send(1'b0, 1'b0, 12'h240, 32'h8000_0010, 32'hF800_0001, 4, 1'b1, acc);
    drain();

    // Reset pulsed during SHIFT
    send(1'b0, 1'b0, 12'hFE0, 32'h0000_0001, 32'h0, 31, 1'b0, acc);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_val2", val2, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);

    // SHIFT_STEP = 1, ROR 31: out_valid 31 edges after acceptance
    @(negedge clk);
    mem_en = 1'b0; I = 1'b0; shifter_operand = 12'hFE0; val_Rm = 32'h0000_0001;
    in_valid1 = 1'b1;
    #1;
    chk("step1_in_ready", {31'd0, in_ready1}, 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    in_valid1 = 1'b0;
    n = 0;
    while (!out_valid1 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!out_valid1) timeout("step1_valid");
    chk("step1_latency", 32'(cyc - acc), 32'd31);
    chk("step1_val2", val2_1, 32'h0000_0002);

    drain();
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
